// File: rtl/mem_stage_dmem_ctrl_if.sv
// Bundles the EX/MEM control inputs, the data-cache bus and the MEM/WB result.
// The controller is the slave; the pipeline and the cache together are the master.
interface mem_stage_dmem_ctrl_if;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        advance;
    logic        stall_req;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] load_data;
    logic        misalign_err;

    modport slave (
        input  mem_read_in, mem_write_in, funct3_in, addr_in, wdata_in, advance,
        input  dmem_rdata, dmem_resp,
        output stall_req, dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        output load_data, misalign_err
    );

    modport master (
        output mem_read_in, mem_write_in, funct3_in, addr_in, wdata_in, advance,
        output dmem_rdata, dmem_resp,
        input  stall_req, dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        input  load_data, misalign_err
    );
endinterface

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: turns the EX/MEM load/store into a cache
// request, stalls the pipeline until the response, and extends the load result.
//
//   state | meaning
//   IDLE  | waiting for a load/store from EX/MEM
//   REQ   | cache request held until dmem_resp
//   DONE  | result held until the pipeline advances
module mem_stage_dmem_ctrl #(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_stage_dmem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state_q, state_d;
    logic            dmem_read_q, dmem_read_d;
    logic            dmem_write_q, dmem_write_d;
    logic            misalign_err_q, misalign_err_d;
    logic [3:0]      mbe_q, mbe_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic            op, is_byte, is_half, is_load, misaligned;
    logic [1:0]      ofs;
    logic [3:0]      store_mbe;
    logic [XLEN-1:0] lane, load_ext, store_wdata;

    assign ofs     = bus.addr_in[1:0];
    assign op      = bus.mem_read_in | bus.mem_write_in;
    assign is_load = bus.mem_read_in;
    // 000/100 are byte accesses, 001/101 halfword; every other encoding is a word.
    assign is_byte = (bus.funct3_in[1:0] == 2'b00);
    assign is_half = (bus.funct3_in[1:0] == 2'b01);
    assign misaligned = is_half ? ofs[0] : (!is_byte && (ofs != 2'b00));
    assign lane    = bus.dmem_rdata >> {ofs, 3'b000};

    always_comb begin
        store_mbe   = 4'hF;
        store_wdata = bus.wdata_in;
        load_ext    = bus.dmem_rdata;
        if (is_byte) begin
            store_mbe   = 4'b0001 << ofs;
            store_wdata = {4{bus.wdata_in[7:0]}};
            load_ext    = {{24{~bus.funct3_in[2] & lane[7]}}, lane[7:0]};
        end else if (is_half) begin
            store_mbe   = 4'b0011 << ofs;
            store_wdata = {2{bus.wdata_in[15:0]}};
            load_ext    = {{16{~bus.funct3_in[2] & lane[15]}}, lane[15:0]};
        end
    end

    always_comb begin
        state_d        = state_q;
        dmem_read_d    = dmem_read_q;
        dmem_write_d   = dmem_write_q;
        mbe_d          = mbe_q;
        load_data_d    = load_data_q;
        misalign_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (op && misaligned) begin
                    state_d        = DONE;
                    load_data_d    = '0;
                    misalign_err_d = 1'b1;
                end else if (op) begin
                    state_d      = REQ;
                    dmem_read_d  = is_load;
                    dmem_write_d = ~is_load;
                    mbe_d        = is_load ? 4'h0 : store_mbe;
                end
            end
            REQ: begin
                if (bus.dmem_resp) begin
                    state_d      = DONE;
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    mbe_d        = 4'h0;
                    if (dmem_read_q) load_data_d = load_ext;
                end
            end
            DONE: begin
                if (bus.advance) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            mbe_q          <= 4'h0;
            load_data_q    <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dmem_read_q    <= dmem_read_d;
            dmem_write_q   <= dmem_write_d;
            mbe_q          <= mbe_d;
            load_data_q    <= load_data_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign bus.stall_req    = op & (state_q != DONE);
    assign bus.dmem_address = {bus.addr_in[31:2], 2'b00};
    assign bus.dmem_read    = dmem_read_q;
    assign bus.dmem_write   = dmem_write_q;
    assign bus.dmem_mbe     = mbe_q;
    assign bus.dmem_wdata   = store_wdata;
    assign bus.load_data    = load_data_q;
    assign bus.misalign_err = misalign_err_q;
endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Self-checking bench for mem_stage_dmem_ctrl: transaction-level reference model
// sets per-cycle expectations, a negedge process compares every cycle.
module tb_mem_stage_dmem_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_dmem_ctrl_if bus_if();
    mem_stage_dmem_ctrl #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    logic exp_stall, exp_rd, exp_wr, exp_err;
    logic [3:0]  exp_mbe;
    logic [31:0] exp_wdata, exp_addr, model_load;
    int stall_cnt = 0, err_cnt = 0, rd_rises = 0;
    logic prev_rd = 1'b0;
    logic [3:0]  cap_mbe;
    logic [31:0] cap_wdata, cap_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Access-level reference: size from funct3, lanes and extension by arithmetic.
    function automatic void ref_access(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic [31:0] rd,
                                       input bit st, output bit mis, output logic [3:0] mbe,
                                       output logic [31:0] wdo, output logic [31:0] ldo);
        int sz, o;
        logic [31:0] lane;
        o    = int'(addr[1:0]);
        sz   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 4);
        mis  = (o % sz) != 0;
        mbe  = st ? 4'(((1 << sz) - 1) << o) : 4'h0;
        lane = rd >> (8 * o);
        if (sz == 1) begin
            wdo = {4{wd[7:0]}};
            ldo = lane & 32'hFF;
            if (f3 == 3'd0 && ldo >= 32'd128) ldo = ldo - 32'd256;
        end else if (sz == 2) begin
            wdo = {2{wd[15:0]}};
            ldo = lane & 32'hFFFF;
            if (f3 == 3'd1 && ldo >= 32'd32768) ldo = ldo - 32'd65536;
        end else begin
            wdo = wd;
            ldo = rd;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_req", 32'(bus_if.stall_req), 32'(exp_stall));
            chk("dmem_read", 32'(bus_if.dmem_read), 32'(exp_rd));
            chk("dmem_write", 32'(bus_if.dmem_write), 32'(exp_wr));
            chk("dmem_mbe", 32'(bus_if.dmem_mbe), 32'(exp_mbe));
            chk("misalign_err", 32'(bus_if.misalign_err), 32'(exp_err));
            chk("load_data", bus_if.load_data, model_load);
            chk("dmem_address", bus_if.dmem_address, exp_addr);
            if (exp_wr) chk("dmem_wdata", bus_if.dmem_wdata, exp_wdata);
            if (bus_if.stall_req) stall_cnt++;
            if (bus_if.misalign_err) err_cnt++;
            if (bus_if.dmem_read && !prev_rd) rd_rises++;
            prev_rd = bus_if.dmem_read;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic r, input logic w, input logic [3:0] m,
                           input logic e);
        exp_stall = s; exp_rd = r; exp_wr = w; exp_mbe = m; exp_err = e;
    endtask

    task automatic idle_cycle();
        bus_if.mem_read_in  = 1'b0;
        bus_if.mem_write_in = 1'b0;
        bus_if.funct3_in    = 3'($urandom);
        bus_if.addr_in      = $urandom;
        bus_if.wdata_in     = $urandom;
        bus_if.advance      = 1'($urandom);
        bus_if.dmem_resp    = 1'($urandom);
        bus_if.dmem_rdata   = $urandom;
        exp_addr = {bus_if.addr_in[31:2], 2'b00};
        set_exp(0, 0, 0, 4'h0, 0);
        chk_en = 1'b1;
        step();
    endtask

    // One load/store: d = REQ cycles (resp in the last), a = DONE cycles before advance.
    task automatic txn(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int d, input int a);
        bit mis;
        logic [3:0] mbe;
        logic [31:0] wdo, ldo;
        ref_access(f3, addr, wd, rd, !ld, mis, mbe, wdo, ldo);
        bus_if.mem_read_in  = ld;
        bus_if.mem_write_in = !ld;
        bus_if.funct3_in    = f3;
        bus_if.addr_in      = addr;
        bus_if.wdata_in     = wd;
        bus_if.advance      = 1'($urandom);
        bus_if.dmem_resp    = 1'($urandom);
        bus_if.dmem_rdata   = $urandom;
        exp_addr  = {addr[31:2], 2'b00};
        exp_wdata = wdo;
        set_exp(1, 0, 0, 4'h0, 0);
        step();
        if (mis) begin
            model_load = 32'h0;
        end else begin
            for (int i = 1; i <= d; i++) begin
                bus_if.advance    = 1'($urandom);
                bus_if.dmem_resp  = (i == d);
                bus_if.dmem_rdata = (i == d) ? rd : $urandom;
                set_exp(1, ld, !ld, mbe, 0);
                if (i == 1) begin
                    #1;
                    cap_mbe   = bus_if.dmem_mbe;
                    cap_wdata = bus_if.dmem_wdata;
                    cap_addr  = bus_if.dmem_address;
                end
                step();
            end
            if (ld) model_load = ldo;
        end
        for (int j = 0; j <= a; j++) begin
            bus_if.advance    = (j == a);
            bus_if.dmem_resp  = 1'($urandom);
            bus_if.dmem_rdata = $urandom;
            set_exp(0, 0, 0, 4'h0, mis && (j == 0));
            step();
        end
    endtask

    initial begin
        int e0, r0;
        rst = 1'b1;
        bus_if.mem_read_in = 1'b0; bus_if.mem_write_in = 1'b0; bus_if.funct3_in = 3'd0;
        bus_if.addr_in = 32'h0; bus_if.wdata_in = 32'h0; bus_if.advance = 1'b0;
        bus_if.dmem_resp = 1'b0; bus_if.dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_data", bus_if.load_data, 32'h0);
        chk("rst_dmem_read", 32'(bus_if.dmem_read), 32'h0);
        chk("rst_dmem_mbe", 32'(bus_if.dmem_mbe), 32'h0);
        chk("rst_misalign", 32'(bus_if.misalign_err), 32'h0);
        chk("rst_stall", 32'(bus_if.stall_req), 32'h0);
        rst = 1'b0;
        model_load = 32'h0;
        repeat (2) idle_cycle();

        stall_cnt = 0;
        txn(1, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 3, 0);
        chk("lb_load_data", bus_if.load_data, 32'hFFFF_FF80);
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd4);

        txn(0, 3'b001, 32'h0000_2002, 32'h1234_ABCD, $urandom, 1, 0);
        chk("sh_mbe", 32'(cap_mbe), 32'h0000_000C);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_address", cap_addr, 32'h0000_2000);

        e0 = err_cnt; r0 = rd_rises; stall_cnt = 0;
        txn(1, 3'b010, 32'h0000_3001, 32'h0, $urandom, 1, 1);
        chk("lw_mis_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("lw_mis_no_request", 32'(rd_rises - r0), 32'd0);
        chk("lw_mis_load_data", bus_if.load_data, 32'h0);
        chk("lw_mis_stall_cycles", 32'(stall_cnt), 32'd1);

        r0 = rd_rises;
        txn(1, 3'b010, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 2, 5);
        chk("held_single_read", 32'(rd_rises - r0), 32'd1);
        chk("held_load_data", bus_if.load_data, 32'hCAFE_F00D);

        txn(1, 3'b101, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 1, 0);
        chk("lhu_load_data", bus_if.load_data, 32'h0000_BEEF);
        txn(0, 3'b000, 32'h0000_4001, 32'h0000_005A, $urandom, 2, 0);
        chk("sb_mbe", 32'(cap_mbe), 32'h0000_0002);
        chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        chk("sb_load_held", bus_if.load_data, 32'h0000_BEEF);

        // Asynchronous reset while a read is outstanding.
        bus_if.mem_read_in = 1'b1; bus_if.mem_write_in = 1'b0; bus_if.funct3_in = 3'b010;
        bus_if.addr_in = 32'h0000_5000; bus_if.advance = 1'b0; bus_if.dmem_resp = 1'b0;
        exp_addr = 32'h0000_5000;
        set_exp(1, 0, 0, 4'h0, 0);
        step();
        set_exp(1, 1, 0, 4'h0, 0);
        step();
        chk_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_dmem_read", 32'(bus_if.dmem_read), 32'h0);
        chk("arst_stall_op", 32'(bus_if.stall_req), 32'h1);
        chk("arst_load_data", bus_if.load_data, 32'h0);
        bus_if.mem_read_in = 1'b0;
        #1;
        chk("arst_stall_noop", 32'(bus_if.stall_req), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_load = 32'h0;
        prev_rd = 1'b0;
        idle_cycle();

        for (int n = 0; n < 200; n++) begin
            bit ld;
            ld = 1'($urandom);
            if ($urandom_range(0, 9) < 3) idle_cycle();
            txn(ld, ld ? 3'($urandom) : 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                $urandom_range(1, 4), $urandom_range(0, 3));
        end
        idle_cycle();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
